// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side request ports and the shared RAM port seen by mem_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the caches and the RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic [ADDR_W-1:0] iload;
    logic              iwait;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [ADDR_W-1:0] dstore;
    logic [ADDR_W-1:0] dload;
    logic              dwait;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [ADDR_W-1:0] ramstore;
    logic [ADDR_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              bus_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, bus_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction and data caches: grant locked per
// transaction, data side preferred, instruction side forced in after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       d_req;
    logic       ram_done;

    assign d_req    = bus.dREN | bus.dWEN;
    assign ram_done = (bus.ramstate == RS_ACCESS) || (bus.ramstate == RS_ERROR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // The counter only grows while a fetch is actually waiting, so it can never pass LIMIT.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.iREN) begin
                    starve_cnt_d = '0;
                end
                if (d_req && (!bus.iREN || starve_cnt_q != LIMIT)) begin
                    state_d = DGNT;
                    if (bus.iREN) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (bus.iREN) begin
                    state_d      = IGNT;
                    starve_cnt_d = '0;
                end
            end
            IGNT: begin
                if (!bus.iREN || ram_done) begin
                    state_d = IDLE;
                end
            end
            DGNT: begin
                if (!d_req || ram_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {ADDR_W{1'b0}};
        bus.ramstore = {ADDR_W{1'b0}};
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = {ADDR_W{1'b0}};
        bus.dload    = {ADDR_W{1'b0}};
        bus.bus_err  = 1'b0;
        unique case (state_q)
            IGNT: begin
                bus.ramaddr = bus.iaddr;
                if (bus.iREN) begin
                    bus.ramREN = 1'b1;
                    if (bus.ramstate == RS_ACCESS) begin
                        bus.iwait = 1'b0;
                        bus.iload = bus.ramload;
                    end
                    bus.bus_err = (bus.ramstate == RS_ERROR);
                end
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                // A combined read+write request is treated as a write.
                if (d_req) begin
                    bus.ramWEN = bus.dWEN;
                    bus.ramREN = ~bus.dWEN;
                    if (bus.ramstate == RS_ACCESS) begin
                        bus.dwait = 1'b0;
                        bus.dload = bus.ramload;
                    end
                    bus.bus_err = (bus.ramstate == RS_ERROR);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single transactions through a scoreboard,
// plus hand-written reset, starvation, error-retry and reset-mid-grant sequences.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef struct {
        bit          is_data;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          busy;
    } vec_t;

    typedef struct {
        bit          is_data;
        bit          exp_ren;
        bit          exp_wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];
    vec_t vecs[6];

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

    mem_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_W      (ADDR_W)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        else
            passes++;
    endtask

    function automatic logic waitOf(input bit is_data);
        return is_data ? bus.dwait : bus.iwait;
    endfunction

    function automatic logic [31:0] loadOf(input bit is_data);
        return is_data ? bus.dload : bus.iload;
    endfunction

    task automatic dropAll();
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    // Drive one request and push what the RAM port and completion should look like.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        bus.iREN   = !v.is_data;
        bus.iaddr  = v.is_data ? 32'h0 : v.addr;
        bus.dREN   = v.is_data && v.ren;
        bus.dWEN   = v.is_data && v.wen;
        bus.daddr  = v.is_data ? v.addr : 32'h0;
        bus.dstore = v.wdata;
        e.is_data  = v.is_data;
        e.exp_wen  = v.is_data && v.wen;
        e.exp_ren  = !(v.is_data && v.wen);
        e.addr     = v.addr;
        e.store    = v.is_data ? v.wdata : 32'h0;
        e.load     = v.rdata;
        exp_q.push_back(e);
    endtask

    task automatic runTransaction(input vec_t v);
        exp_t e;
        int   lat;
        lat = 0;
        bus.ramstate = RS_FREE;
        bus.ramload  = v.rdata;
        applyStimulus(v);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (bus.ramREN || bus.ramWEN) begin
                lat = c;
                break;
            end
        end
        checkOutput("grant_latency", 32'(lat), 32'd1);
        e = exp_q.pop_front();
        checkOutput("grant_ramREN", 32'(bus.ramREN), 32'(e.exp_ren));
        checkOutput("grant_ramWEN", 32'(bus.ramWEN), 32'(e.exp_wen));
        checkOutput("grant_ramaddr", bus.ramaddr, e.addr);
        checkOutput("grant_ramstore", bus.ramstore, e.store);
        checkOutput("grant_wait", 32'(waitOf(e.is_data)), 32'd1);
        tick();
        for (int b = 0; b < v.busy; b++) begin
            bus.ramstate = RS_BUSY;
            #1;
            checkOutput("busy_wait", 32'(waitOf(e.is_data)), 32'd1);
            checkOutput("busy_ramaddr", bus.ramaddr, e.addr);
            tick();
        end
        bus.ramstate = RS_ACCESS;
        #1;
        checkOutput("done_wait", 32'(waitOf(e.is_data)), 32'd0);
        checkOutput("done_load", loadOf(e.is_data), e.load);
        checkOutput("done_other_wait", 32'(waitOf(!e.is_data)), 32'd1);
        checkOutput("done_other_load", loadOf(!e.is_data), 32'h0);
        checkOutput("done_bus_err", 32'(bus.bus_err), 32'd0);
        tick();
        dropAll();
        bus.ramstate = RS_FREE;
        #1;
        checkOutput("after_enables", {30'h0, bus.ramREN, bus.ramWEN}, 32'd0);
        checkOutput("after_wait", 32'(waitOf(e.is_data)), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dgrants;
        bit igrant;

        vecs[0] = '{is_data:1'b0, ren:1'b1, wen:1'b0, addr:32'h0000_0040, wdata:32'h1111_2222, rdata:32'h8C22_0004, busy:0};
        vecs[1] = '{is_data:1'b1, ren:1'b1, wen:1'b1, addr:32'h0000_0100, wdata:32'hDEAD_BEEF, rdata:32'h0BAD_F00D, busy:0};
        vecs[2] = '{is_data:1'b1, ren:1'b1, wen:1'b0, addr:32'h0000_1234, wdata:32'h5555_AAAA, rdata:32'hCAFE_F00D, busy:2};
        vecs[3] = '{is_data:1'b1, ren:1'b0, wen:1'b1, addr:32'hFFFF_FFFC, wdata:32'h0000_0000, rdata:32'h7777_7777, busy:1};
        vecs[4] = '{is_data:1'b0, ren:1'b1, wen:1'b0, addr:32'hFFFF_FFFF, wdata:32'h0000_0000, rdata:32'hFFFF_FFFF, busy:3};
        vecs[5] = '{is_data:1'b1, ren:1'b1, wen:1'b0, addr:32'h0000_0000, wdata:32'h0000_0001, rdata:32'hA5A5_A5A5, busy:0};

        // Reset with both sides requesting: nothing may reach RAM.
        rst = 1'b1;
        bus.iREN = 1'b1; bus.iaddr = 32'h0000_0080;
        bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'h0000_0200; bus.dstore = 32'h0;
        bus.ramload = 32'h0; bus.ramstate = RS_FREE;
        tick();
        tick();
        checkOutput("reset_enables", {30'h0, bus.ramREN, bus.ramWEN}, 32'd0);
        checkOutput("reset_waits", {30'h0, bus.iwait, bus.dwait}, 32'd3);
        checkOutput("reset_bus_err", 32'(bus.bus_err), 32'd0);
        checkOutput("reset_ramaddr", bus.ramaddr, 32'h0);
        checkOutput("reset_loads", bus.iload | bus.dload, 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("first_grant_data_ren", 32'(bus.ramREN), 32'd1);
        checkOutput("first_grant_data_addr", bus.ramaddr, 32'h0000_0200);
        // Withdrawal before ACCESS: enables fall at once, no completion.
        dropAll();
        #1;
        checkOutput("withdraw_enables", {30'h0, bus.ramREN, bus.ramWEN}, 32'd0);
        checkOutput("withdraw_dwait", 32'(bus.dwait), 32'd1);
        tick();
        tick();

        foreach (vecs[i]) runTransaction(vecs[i]);

        // Starvation: data side re-requests forever, fetch must win after 4 data grants, twice.
        bus.iREN = 1'b1; bus.iaddr = 32'h0000_0080;
        bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'h0000_0300;
        bus.ramload = 32'h2468_ACE0; bus.ramstate = RS_ACCESS;
        for (int round = 0; round < 2; round++) begin
            dgrants = 0;
            igrant  = 1'b0;
            for (int c = 0; c < 40 && !igrant; c++) begin
                tick();
                if (bus.ramREN) begin
                    if (bus.ramaddr == 32'h0000_0080) igrant = 1'b1;
                    else dgrants++;
                end
            end
            checkOutput("starve_igrant", 32'(igrant), 32'd1);
            checkOutput("starve_dgrants", 32'(dgrants), 32'd4);
            checkOutput("starve_iwait", 32'(bus.iwait), 32'd0);
            checkOutput("starve_iload", bus.iload, 32'h2468_ACE0);
        end
        dropAll();
        bus.ramstate = RS_FREE;
        tick();
        tick();

        // RAM error on a data read, then successful retry.
        bus.dREN = 1'b1; bus.daddr = 32'h0000_0500; bus.ramload = 32'h1357_9BDF;
        tick();
        bus.ramstate = RS_ERROR;
        #1;
        checkOutput("err_bus_err", 32'(bus.bus_err), 32'd1);
        checkOutput("err_dwait", 32'(bus.dwait), 32'd1);
        tick();
        bus.ramstate = RS_FREE;
        #1;
        checkOutput("err_idle_bus_err", 32'(bus.bus_err), 32'd0);
        checkOutput("err_idle_ren", 32'(bus.ramREN), 32'd0);
        checkOutput("err_idle_dwait", 32'(bus.dwait), 32'd1);
        tick();
        checkOutput("retry_ren", 32'(bus.ramREN), 32'd1);
        checkOutput("retry_addr", bus.ramaddr, 32'h0000_0500);
        bus.ramstate = RS_ACCESS;
        #1;
        checkOutput("retry_dwait", 32'(bus.dwait), 32'd0);
        checkOutput("retry_dload", bus.dload, 32'h1357_9BDF);
        checkOutput("retry_bus_err", 32'(bus.bus_err), 32'd0);
        tick();
        dropAll();
        bus.ramstate = RS_FREE;
        tick();

        // Reset while a fetch is in progress with RAM busy.
        bus.iREN = 1'b1; bus.iaddr = 32'h0000_0600;
        tick();
        bus.ramstate = RS_BUSY;
        #1;
        checkOutput("midrst_pre_ren", 32'(bus.ramREN), 32'd1);
        checkOutput("midrst_pre_iwait", 32'(bus.iwait), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("midrst_ren", 32'(bus.ramREN), 32'd0);
        checkOutput("midrst_iwait", 32'(bus.iwait), 32'd1);
        bus.ramstate = RS_ACCESS;
        #1;
        checkOutput("midrst_no_complete", 32'(bus.iwait), 32'd1);
        rst = 1'b0;
        dropAll();
        bus.ramstate = RS_FREE;
        tick();
        checkOutput("midrst_after_iwait", 32'(bus.iwait), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
